// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the F/D/E/M/W hazard controller: scoreboard entries, FSM states, counter width.
package hazard_scoreboard_pkg;

  typedef enum logic {
    SB_LOAD   = 1'b0,
    SB_MULDIV = 1'b1
  } sb_type_e;

  typedef struct packed {
    logic     pend;
    sb_type_e typ;
  } sb_entry_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_DROP = 1'b1
  } hz_state_e;

  localparam int MULDIV_CNT_W = 4;
  localparam int CREG_AW      = 5;

  typedef logic [CREG_AW-1:0] creg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/memory status into the hazard controller and stall/flush/issue back out.
interface hazard_scoreboard_if #(
  parameter int ISSUE_W = 1,
  parameter int AW      = 5
);
  logic                  i_data_ok;
  logic                  d_data_ok;
  logic [ISSUE_W-1:0]    d_valid;
  logic [ISSUE_W*AW-1:0] d_srca;
  logic [ISSUE_W*AW-1:0] d_srcb;
  logic [ISSUE_W-1:0]    d_usea;
  logic [ISSUE_W-1:0]    d_useb;
  logic [ISSUE_W*AW-1:0] d_dst;
  logic [ISSUE_W-1:0]    d_regwrite;
  logic [ISSUE_W-1:0]    d_load;
  logic [ISSUE_W-1:0]    d_muldiv;
  logic [ISSUE_W-1:0]    d_branch;
  logic [ISSUE_W-1:0]    e_regwrite;
  logic [ISSUE_W*AW-1:0] e_dst;
  logic                  ld_done;
  logic [AW-1:0]         ld_reg;
  logic                  exc_flush;

  logic [ISSUE_W-1:0]    issue_ok;
  logic                  stallF, stallD, stallE, stallM;
  logic                  flushD, flushE, flushM, flushW;
  logic                  muldiv_busy;

  modport master (
    output i_data_ok, d_data_ok, d_valid, d_srca, d_srcb, d_usea, d_useb, d_dst,
           d_regwrite, d_load, d_muldiv, d_branch, e_regwrite, e_dst, ld_done, ld_reg, exc_flush,
    input  issue_ok, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, muldiv_busy
  );

  modport slave (
    input  i_data_ok, d_data_ok, d_valid, d_srca, d_srcb, d_usea, d_useb, d_dst,
           d_regwrite, d_load, d_muldiv, d_branch, e_regwrite, e_dst, ld_done, ld_reg, exc_flush,
    output issue_ok, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, muldiv_busy
  );

endinterface

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// Per-register pending table for loads and the single mul/div unit, with its latency countdown.
// Clears are applied before sets so a same-cycle re-issue to the same register stays pending.
module reg_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ISSUE_W    = 1,
  parameter int NREG       = 32,
  parameter int MULDIV_LAT = 4,
  parameter int AW         = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ISSUE_W-1:0]      set_vld,
  input  logic [ISSUE_W*AW-1:0]   set_reg,
  input  logic [ISSUE_W-1:0]      set_md,
  input  logic                    ld_clr,
  input  logic [AW-1:0]           ld_reg,
  input  logic                    flush_ld,
  output logic [NREG-1:0]         pend,
  output logic [MULDIV_CNT_W-1:0] cnt
);

  sb_entry_t               sb_q [NREG];
  logic [AW-1:0]           md_reg_q;
  logic [MULDIV_CNT_W-1:0] cnt_q;
  logic                    md_set;
  logic [AW-1:0]           md_set_reg;

  always_comb begin
    md_set     = 1'b0;
    md_set_reg = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      if (set_vld[s] && set_md[s]) begin
        md_set     = 1'b1;
        md_set_reg = set_reg[s*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        sb_q[r] <= '{pend: 1'b0, typ: SB_LOAD};
      end
      cnt_q    <= '0;
      md_reg_q <= '0;
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - MULDIV_CNT_W'(1);
      end
      // The mul/div result becomes forwardable as the count leaves 1.
      if (cnt_q == MULDIV_CNT_W'(1) && sb_q[md_reg_q].typ == SB_MULDIV) begin
        sb_q[md_reg_q].pend <= 1'b0;
      end
      if (flush_ld) begin
        for (int r = 0; r < NREG; r++) begin
          if (sb_q[r].typ == SB_LOAD) begin
            sb_q[r].pend <= 1'b0;
          end
        end
      end
      if (ld_clr && sb_q[ld_reg].typ == SB_LOAD) begin
        sb_q[ld_reg].pend <= 1'b0;
      end
      for (int s = 0; s < ISSUE_W; s++) begin
        if (set_vld[s]) begin
          sb_q[set_reg[s*AW +: AW]].pend <= 1'b1;
          sb_q[set_reg[s*AW +: AW]].typ  <= set_md[s] ? SB_MULDIV : SB_LOAD;
        end
      end
      if (md_set) begin
        cnt_q    <= MULDIV_CNT_W'(MULDIV_LAT);
        md_reg_q <= md_set_reg;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend[r] = sb_q[r].pend;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: per-slot RAW/branch/structural blocking, 1- or 2-wide issue, stage stall/flush, stale-fetch drop FSM.
// Outputs are combinational from registered state and current inputs.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ISSUE_W    = 1,
  parameter int NREG       = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  hazard_scoreboard_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0]         pend;
  logic [MULDIV_CNT_W-1:0] cnt;
  logic                    cnt_gt1;
  logic                    exc_act;
  logic [ISSUE_W-1:0]      blk_own;
  logic [ISSUE_W-1:0]      blk;
  logic [ISSUE_W-1:0]      iss;
  logic [ISSUE_W-1:0]      set_vld;
  logic                    s_f, s_d, s_e, s_m;
  logic                    f_d, f_e, f_m, f_w;
  hz_state_e               state_q, state_d;

  assign cnt_gt1 = cnt > MULDIV_CNT_W'(1);
  assign exc_act = bus.exc_flush && bus.d_data_ok;

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
    logic [AW-1:0] a, b, d;
    logic          raw, br_hit;

    assign a   = bus.d_srca[s*AW +: AW];
    assign b   = bus.d_srcb[s*AW +: AW];
    assign d   = bus.d_dst[s*AW +: AW];
    assign raw = (bus.d_usea[s] && a != '0 && pend[a]) ||
                 (bus.d_useb[s] && b != '0 && pend[b]);

    // A branch resolving in D cannot see a result still sitting in E.
    always_comb begin
      br_hit = 1'b0;
      for (int k = 0; k < ISSUE_W; k++) begin
        if (bus.e_regwrite[k] && bus.e_dst[k*AW +: AW] != '0 &&
            ((bus.d_usea[s] && a == bus.e_dst[k*AW +: AW]) ||
             (bus.d_useb[s] && b == bus.e_dst[k*AW +: AW]))) begin
          br_hit = 1'b1;
        end
      end
    end

    assign blk_own[s] = bus.d_valid[s] &&
                        (raw || (bus.d_branch[s] && br_hit) || (bus.d_muldiv[s] && cnt_gt1));
    assign set_vld[s] = iss[s] && bus.d_regwrite[s] && (bus.d_load[s] || bus.d_muldiv[s]) && d != '0;
  end

  if (ISSUE_W == 2) begin : g_pair
    logic [AW-1:0] d0, a1, b1;
    logic          dep;

    assign d0  = bus.d_dst[AW-1:0];
    assign a1  = bus.d_srca[2*AW-1:AW];
    assign b1  = bus.d_srcb[2*AW-1:AW];
    assign dep = bus.d_regwrite[0] && d0 != '0 &&
                 ((bus.d_usea[1] && a1 == d0) || (bus.d_useb[1] && b1 == d0));

    assign blk[0] = blk_own[0];
    assign blk[1] = blk_own[1] || !bus.d_valid[0] || blk_own[0] || dep ||
                    (bus.d_load[0] && bus.d_load[1]) || (bus.d_muldiv[0] && bus.d_muldiv[1]);
  end else begin : g_single
    assign blk = blk_own;
  end

  always_comb begin
    iss = '0;
    s_f = 1'b0; s_d = 1'b0; s_e = 1'b0; s_m = 1'b0;
    f_d = 1'b0; f_e = 1'b0; f_m = 1'b0; f_w = 1'b0;
    if (!resetn) begin
      f_d = 1'b1; f_e = 1'b1; f_m = 1'b1; f_w = 1'b1;
    end else if (exc_act) begin
      f_d = 1'b1; f_e = 1'b1; f_m = 1'b1;
    end else if (!bus.d_data_ok) begin
      s_f = 1'b1; s_d = 1'b1; s_e = 1'b1; s_m = 1'b1;
      f_w = 1'b1;
    end else if (state_q == HZ_DROP) begin
      f_d = 1'b1;
    end else if (!bus.i_data_ok || blk[0]) begin
      s_f = 1'b1; s_d = 1'b1;
      f_e = 1'b1;
    end else begin
      // Slot-1-only blocks issue slot 0 alone; the frontend rebundles slot 1.
      iss = bus.d_valid & ~blk;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:  if (exc_act && !bus.i_data_ok) state_d = HZ_DROP;
      HZ_DROP: if (!exc_act && bus.i_data_ok) state_d = HZ_RUN;
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  reg_scoreboard #(
    .ISSUE_W    (ISSUE_W),
    .NREG       (NREG),
    .MULDIV_LAT (MULDIV_LAT),
    .AW         (AW)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .set_vld  (set_vld),
    .set_reg  (bus.d_dst),
    .set_md   (bus.d_muldiv),
    .ld_clr   (bus.ld_done && bus.d_data_ok),
    .ld_reg   (bus.ld_reg),
    .flush_ld (exc_act),
    .pend     (pend),
    .cnt      (cnt)
  );

  assign bus.issue_ok    = iss;
  assign bus.stallF      = s_f;
  assign bus.stallD      = s_d;
  assign bus.stallE      = s_e;
  assign bus.stallM      = s_m;
  assign bus.flushD      = f_d;
  assign bus.flushE      = f_e;
  assign bus.flushM      = f_m;
  assign bus.flushW      = f_w;
  assign bus.muldiv_busy = resetn && (cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (2-wide, 32 regs, mul/div latency 4) with hand-computed expectations.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.ISSUE_W(2), .AW(5)) bus ();

  hazard_scoreboard #(.ISSUE_W(2), .NREG(32), .MULDIV_LAT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected layout: issue_ok[1:0], stallF/D/E/M, flushD/E/M/W, muldiv_busy.
  function automatic logic [10:0] mk(input logic [1:0] iss, input logic [3:0] st,
                                     input logic [3:0] fl, input logic busy);
    return {iss, st, fl, busy};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.issue_ok, bus.stallF, bus.stallD, bus.stallE, bus.stallM,
            bus.flushD, bus.flushE, bus.flushM, bus.flushW, bus.muldiv_busy};
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.i_data_ok  = 1'b1;
    bus.d_data_ok  = 1'b1;
    bus.d_valid    = '0;
    bus.d_srca     = '0;
    bus.d_srcb     = '0;
    bus.d_usea     = '0;
    bus.d_useb     = '0;
    bus.d_dst      = '0;
    bus.d_regwrite = '0;
    bus.d_load     = '0;
    bus.d_muldiv   = '0;
    bus.d_branch   = '0;
    bus.e_regwrite = '0;
    bus.e_dst      = '0;
    bus.ld_done    = 1'b0;
    bus.ld_reg     = '0;
    bus.exc_flush  = 1'b0;
  endtask

  task automatic set_slot(input int s, input creg_addr_t a, input logic ua, input creg_addr_t b,
                          input logic ub, input creg_addr_t d, input logic rw, input logic ld,
                          input logic md, input logic br);
    bus.d_valid[s]         = 1'b1;
    bus.d_srca[s*5 +: 5]   = a;
    bus.d_usea[s]          = ua;
    bus.d_srcb[s*5 +: 5]   = b;
    bus.d_useb[s]          = ub;
    bus.d_dst[s*5 +: 5]    = d;
    bus.d_regwrite[s]      = rw;
    bus.d_load[s]          = ld;
    bus.d_muldiv[s]        = md;
    bus.d_branch[s]        = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input string tag, input logic [10:0] exp);
    #1;
    chk(tag, obs(), exp);
    tick();
  endtask

  localparam logic [10:0] RST   = 11'b00_0000_1111_0;
  localparam logic [10:0] GO0   = 11'b01_0000_0000_0;
  localparam logic [10:0] STL   = 11'b00_1100_0100_0;
  localparam logic [10:0] EXC   = 11'b00_0000_1110_0;
  localparam logic [10:0] DROP  = 11'b00_0000_1000_0;
  localparam logic [10:0] DWAIT = 11'b00_1111_0001_0;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle();
    #2;
    chk("reset_state", obs(), RST);
    #10 resetn = 1'b1;
    tick();

    // Load-use stall until the load data returns
    idle(); set_slot(0, 0, 0, 0, 0, 5, 1, 1, 0, 0);  cyc("t1_load_issue", GO0);
    idle(); set_slot(0, 5, 1, 0, 0, 7, 1, 0, 0, 0);  cyc("t1_raw_stall", STL);
    idle(); set_slot(0, 5, 1, 0, 0, 7, 1, 0, 0, 0);
    bus.ld_done = 1'b1; bus.ld_reg = 5;             cyc("t1_ld_done_cycle", STL);
    idle(); set_slot(0, 5, 1, 0, 0, 7, 1, 0, 0, 0);  cyc("t1_release", GO0);

    // Mul/div: consumer waits 4 cycles; a second mult issues at cnt==1
    idle(); set_slot(0, 0, 0, 0, 0, 8, 1, 0, 1, 0);  cyc("t2_mult_issue", GO0);
    for (int i = 0; i < 4; i++) begin
      idle(); set_slot(0, 8, 1, 0, 0, 9, 1, 0, 0, 0); cyc("t2_consumer_wait", mk(2'b00, 4'b1100, 4'b0100, 1'b1));
    end
    idle(); set_slot(0, 8, 1, 0, 0, 9, 1, 0, 0, 0);  cyc("t2_consumer_go", GO0);
    idle(); set_slot(0, 0, 0, 0, 0, 10, 1, 0, 1, 0); cyc("t2_mult_a", GO0);
    for (int i = 0; i < 3; i++) begin
      idle(); set_slot(0, 0, 0, 0, 0, 11, 1, 0, 1, 0); cyc("t2_mult_b_struct", mk(2'b00, 4'b1100, 4'b0100, 1'b1));
    end
    idle(); set_slot(0, 0, 0, 0, 0, 11, 1, 0, 1, 0); cyc("t2_mult_b_b2b", mk(2'b01, 4'b0000, 4'b0000, 1'b1));
    idle(); set_slot(0, 10, 1, 0, 0, 9, 1, 0, 0, 0); cyc("t2_reads_a_free", mk(2'b01, 4'b0000, 4'b0000, 1'b1));
    idle(); set_slot(0, 11, 1, 0, 0, 9, 1, 0, 0, 0); cyc("t2_reads_b_wait", mk(2'b00, 4'b1100, 4'b0100, 1'b1));
    idle(); tick(); tick(); tick();
    idle();                                          cyc("t2_drained", mk(2'b00, 4'b0000, 4'b0000, 1'b0));

    // Dual issue pairing rules
    idle(); set_slot(0, 1, 1, 0, 0, 3, 1, 0, 0, 0); set_slot(1, 3, 1, 0, 0, 12, 1, 0, 0, 0);
    cyc("t3_dep_split", GO0);
    idle(); set_slot(0, 0, 0, 0, 0, 13, 1, 1, 0, 0); set_slot(1, 0, 0, 0, 0, 14, 1, 1, 0, 0);
    cyc("t3_two_loads", GO0);
    idle(); set_slot(0, 1, 1, 0, 0, 15, 1, 0, 0, 0); set_slot(1, 2, 1, 0, 0, 16, 1, 0, 0, 0);
    cyc("t3_dual", mk(2'b11, 4'b0000, 4'b0000, 1'b0));
    idle(); set_slot(0, 14, 1, 0, 0, 19, 1, 0, 0, 0); cyc("t3_slot1_load_not_set", GO0);
    idle(); set_slot(0, 13, 1, 0, 0, 17, 1, 0, 0, 0); set_slot(1, 2, 1, 0, 0, 18, 1, 0, 0, 0);
    bus.ld_done = 1'b1; bus.ld_reg = 13;
    cyc("t3_slot0_raw", STL);

    // Branch in D against an E-stage producer
    idle(); set_slot(0, 4, 1, 6, 1, 0, 0, 0, 0, 1);
    bus.e_regwrite = 2'b01; bus.e_dst = 10'd6;       cyc("t4_branch_e0", STL);
    idle(); set_slot(0, 4, 1, 6, 1, 0, 0, 0, 0, 1);  cyc("t4_branch_go", GO0);
    idle(); set_slot(0, 4, 1, 6, 1, 0, 0, 0, 0, 1);
    bus.e_regwrite = 2'b10; bus.e_dst = {5'd4, 5'd0}; cyc("t4_branch_e1", STL);
    idle(); set_slot(0, 0, 1, 6, 0, 0, 0, 0, 0, 1);
    bus.e_regwrite = 2'b11; bus.e_dst = '0;          cyc("t4_edst_zero", GO0);
    idle(); bus.i_data_ok = 1'b0; set_slot(0, 1, 1, 0, 0, 24, 1, 0, 0, 0);
    cyc("t4_ifetch_wait", STL);

    // Exception flush and stale-fetch drop
    idle(); set_slot(0, 0, 0, 0, 0, 20, 1, 1, 0, 0); cyc("t5_load20", GO0);
    idle(); bus.exc_flush = 1'b1; bus.i_data_ok = 1'b0; cyc("t5_exc", EXC);
    idle(); bus.i_data_ok = 1'b0;                    cyc("t5_drop_wait", DROP);
    idle();                                          cyc("t5_drop_return", DROP);
    idle(); set_slot(0, 20, 1, 0, 0, 25, 1, 0, 0, 0); cyc("t5_load_cleared", GO0);
    idle(); bus.exc_flush = 1'b1; bus.i_data_ok = 1'b0; cyc("t5_exc2", EXC);
    idle(); bus.exc_flush = 1'b1;                    cyc("t5_exc_in_drop", EXC);
    idle();                                          cyc("t5_still_drop", DROP);
    idle(); set_slot(0, 1, 1, 0, 0, 26, 1, 0, 0, 0); cyc("t5_run", GO0);

    // Data-memory wait freezes the load scoreboard; async reset clears everything
    idle(); set_slot(0, 0, 0, 0, 0, 21, 1, 1, 0, 0); cyc("t6_load21", GO0);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.d_data_ok = 1'b0; set_slot(0, 21, 1, 0, 0, 27, 1, 0, 0, 0);
      if (i == 1) begin
        bus.ld_done = 1'b1; bus.ld_reg = 21;
      end
      cyc("t6_dmem_wait", DWAIT);
    end
    idle(); set_slot(0, 21, 1, 0, 0, 27, 1, 0, 0, 0); cyc("t6_frozen_raw", STL);
    idle(); set_slot(0, 21, 1, 0, 0, 27, 1, 0, 0, 0);
    #1 resetn = 1'b0;
    #1 chk("t6_async_reset", obs(), RST);
    #2 resetn = 1'b1;
    tick();
    idle(); set_slot(0, 21, 1, 0, 0, 27, 1, 0, 0, 0); cyc("t6_after_reset", GO0);
    idle(); bus.exc_flush = 1'b1; bus.i_data_ok = 1'b0; cyc("t6_exc", EXC);
    idle(); bus.i_data_ok = 1'b0;
    #1 chk("t6_in_drop", obs(), DROP);
    resetn = 1'b0;
    #1 chk("t6_reset_drop", obs(), RST);
    #2 resetn = 1'b1;
    tick();
    idle(); set_slot(0, 1, 1, 0, 0, 28, 1, 0, 0, 0); cyc("t6_run_after_reset", GO0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
